spi_reg_bridge: RTL

//  Bridges the SPI byte stream to the PWM register file.
//  - Decodes a command byte, then issues single-cycle read/write strobes on the register file's addr/high_byte/data bus.
//  - Returns read data to the SPI shifter.
//  - Sits between the SPI slave byte interface and the register file; it is the only master of that register bus.

---
 rtl/spi_reg_bridge.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   Bridges the SPI slave byte stream to the PWM register file. The first byte
//   of each frame is a command. Bit 7 selects write (1) or read (0), bit 6
//   selects the high byte, and bits 5:0 give the address. The bridge then issues
//   single-cycle read/write strobes on the register bus and returns read data
//   to the SPI shifter. It is the only master of that register bus.
//
//   Handshake: rx_valid is a one-cycle pulse that qualifies rx_byte. tx_load is
//   a one-cycle pulse that qualifies tx_byte. There is no back-pressure in
//   either direction. reg_read and reg_write are one-cycle strobes.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   cs_active       SPI frame active (already synchronised)
//   rx_valid/rx_byte    received byte from the SPI shifter
//   tx_byte/tx_load     next byte for the SPI shifter
//   reg_read/reg_write  register bus strobes
//   reg_addr/reg_high_byte/reg_data_write  register bus address/data
//   reg_data_read   register read data (combinational in the register file)
//   busy            high whenever the FSM is not idle
//   frame_err       one-cycle pulse: a write frame ended with no data byte
module spi_reg_bridge #(
  parameter bit BURST_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic       tx_load,
  output logic       reg_read,
  output logic       reg_write,
  output logic [5:0] reg_addr,
  output logic       reg_high_byte,
  output logic [7:0] reg_data_write,
  input  logic [7:0] reg_data_read,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_WR_DATA  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t     r_state;
  logic [7:0] r_tx_byte;
  logic       r_tx_load;
  logic       r_reg_read;
  logic       r_reg_write;
  logic [5:0] r_reg_addr;
  logic       r_reg_high_byte;
  logic [7:0] r_reg_data_write;
  logic       r_frame_err;
  // Set once cs_active has been seen low. After a reset that lands mid-frame,
  // the rest of that frame must be ignored. A new frame may only start after
  // a deassertion of cs_active.
  logic       r_armed;
  // A data byte was received in the current write frame.
  logic       r_got_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_tx_byte        <= 8'h00;
      r_tx_load        <= 1'b0;
      r_reg_read       <= 1'b0;
      r_reg_write      <= 1'b0;
      r_reg_addr       <= 6'h00;
      r_reg_high_byte  <= 1'b0;
      r_reg_data_write <= 8'h00;
      r_frame_err      <= 1'b0;
      r_armed          <= 1'b0;
      r_got_data       <= 1'b0;
    end else begin
      // Strobes are single-cycle by default.
      r_reg_read  <= 1'b0;
      r_reg_write <= 1'b0;
      r_tx_load   <= 1'b0;
      r_frame_err <= 1'b0;

      if (!cs_active) begin
        // End of frame has priority. A byte arriving in the same cycle is
        // dropped. Address, data and tx_byte keep their last values.
        r_armed     <= 1'b1;
        r_frame_err <= (r_state == ST_WR_DATA) && !r_got_data;
        r_state     <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_armed) begin
              r_state    <= ST_CMD;
              r_got_data <= 1'b0;
            end
          end
          ST_CMD: begin
            if (rx_valid) begin
              r_reg_addr      <= rx_byte[5:0];
              r_reg_high_byte <= rx_byte[6];
              if (rx_byte[7]) begin
                r_state <= ST_WR_DATA;
              end else begin
                r_state    <= ST_RD_ISSUE;
                r_reg_read <= 1'b1;
              end
            end
          end
          ST_WR_DATA: begin
            // Advance the address one cycle after the write strobe. The
            // address then stays stable while the strobe is high.
            if (r_reg_write && BURST_EN) begin
              r_reg_addr <= r_reg_addr + 6'd1;
            end
            if (rx_valid) begin
              r_reg_write      <= 1'b1;
              r_reg_data_write <= rx_byte;
              r_got_data       <= 1'b1;
              if (!BURST_EN) begin
                r_state <= ST_DONE;
              end
            end
          end
          ST_RD_ISSUE: begin
            // reg_read is high in this cycle. Capture the combinational read
            // data here.
            r_tx_byte <= reg_data_read;
            r_tx_load <= 1'b1;
            r_state   <= ST_RD_WAIT;
          end
          ST_RD_WAIT: begin
            // A dummy byte means the previous tx_byte has been shifted out.
            if (rx_valid) begin
              if (BURST_EN) begin
                r_reg_addr <= r_reg_addr + 6'd1;
                r_reg_read <= 1'b1;
                r_state    <= ST_RD_ISSUE;
              end else begin
                r_state <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_DONE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_byte        = r_tx_byte;
  assign tx_load        = r_tx_load;
  assign reg_read       = r_reg_read;
  assign reg_write      = r_reg_write;
  assign reg_addr       = r_reg_addr;
  assign reg_high_byte  = r_reg_high_byte;
  assign reg_data_write = r_reg_data_write;
  assign frame_err      = r_frame_err;
  assign busy           = (r_state != ST_IDLE);

  // The SPI byte time is at least 8 clocks, so a byte can never land in the
  // single RD_ISSUE cycle.
  a_no_rx_in_rd_issue: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_state == ST_RD_ISSUE && cs_active && rx_valid));

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_reg_read && r_reg_write));

endmodule
